alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencing arbiter sharing one 32-bit ALU datapath between two requesters. Accepts one operation at a time via per-requester request/grant handshake, drives the ALU operand and op inputs from internal registers, captures result and flags after one settle cycle, and holds them on a response port until acknowledged. Sits between the two issuing units and the ALU instance, wired to it at the parent level.

## Interface
Parameters:
- none (widths fixed: 32-bit data, 3-bit op)

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- Req0 / Req1  in  1  request from requester 0 / 1
- A0, B0 / A1, B1  in  32  operands of requester 0 / 1
- Op0 / Op1  in  3  op code {Op2,Op1,Op0} of requester 0 / 1, passed to ALU unmodified
- Gnt0 / Gnt1  out  1  grant; transfer when ReqN && GntN at rising edge
- AluA, AluB  out  32  operands to ALU
- AluOp  out  3  op code to ALU
- AluR  in  32  ALU result
- AluC, AluV, AluZ  in  1  ALU carry-out, overflow, zero
- RspValid  out  1  response valid
- RspAck  in  1  response consumed
- RspId  out  1  requester index of response
- RspR  out  32  captured result
- RspC, RspV, RspZ  out  1  captured flags
- Busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: GntN combinational; at most one grant high. Only Req0 -> Gnt0; only Req1 -> Gnt1; both -> requester selected by priority (see Configuration). On transfer edge: latch A, B, Op into AluA/AluB/AluOp registers, latch RspId, go EXEC.
- EXEC: one cycle; Gnt0 = Gnt1 = 0; ALU settles from registered inputs. At edge: capture AluR/AluC/AluV/AluZ into RspR/RspC/RspV/RspZ, set RspValid, go RESP.
- RESP: RspValid = 1, all Rsp* stable. On edge with RspAck = 1: clear RspValid, go IDLE. RspAck = 0: stay.
- Arbiter does not interpret op codes; subtract/SLT semantics belong to the ALU.
- Requester must hold ReqN, operands, op stable until grant; dropping ReqN before grant cancels with no effect.
- RspAck while RspValid = 0: ignored.
- AluA/AluB/AluOp hold last issued values outside EXEC.
- Reset (any state, any time): state IDLE; Gnt0 = Gnt1 = 0 during reset; AluA = AluB = 0, AluOp = 0; RspValid = 0, RspId = 0, RspR = 0, RspC = RspV = RspZ = 0; Busy = 0; priority pointer = requester 0. In-flight operation discarded, no response.

## Timing
- Transfer at edge N -> EXEC during cycle N..N+1 -> RspValid high after edge N+1 (latency 2 edges).
- RspAck at edge M -> IDLE after M; next grant earliest at edge M+1 (no bypass). Minimum 3 cycles per operation.
- Gnt is combinational from ReqN and state only; no combinational path from AluR/flags to any output.
- Busy registered-state-derived, glitch-free with respect to Req inputs.

## Configuration
- ALU_ARB_RR_EN defined: round-robin. 1-bit pointer names preferred requester on simultaneous Req; after each grant pointer points to the non-granted requester. Pointer unchanged when only one requester active... no: pointer always set to other than the one granted.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins on simultaneous Req; pointer logic absent.

## Test plan
Bench wires a real ALU; op 3'b010 = add, 3'b110 = subtract.
- Req0, A0=5, B0=7, Op0=010 -> Gnt0 one cycle, RspValid 2 edges later, RspId=0, RspR=12, RspZ=0, RspC=0.
- Req1, A1=0x7FFFFFFF, B1=1, Op1=010 -> RspR=0x80000000, RspV=1, RspId=1; hold RspAck=0 for 5 cycles -> Rsp* unchanged, Gnt0/Gnt1 stay 0 despite new requests.
- Req1, A1=9, B1=9, Op1=110 -> RspR=0, RspZ=1, RspC=1.
- Req0 and Req1 held high for 4 transactions -> RR_EN: grants 0,1,0,1; without RR_EN: 0,0,0,0.
- Assert Rst during EXEC of A0=3,B0=4 -> RspValid stays 0, all outputs at reset values, Busy=0; after release, new Req1 served normally with RspId=1.
- RspAck pulsed while IDLE -> no state change; RspAck same edge as Req0 in RESP -> Gnt0 not before following cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two requesters.
// Each operation goes IDLE -> EXEC -> RESP. The arbiter issues the operands and
// op code from registers, captures the result and flags one settle cycle later,
// and holds them on the response port until RspAck.
// Optional feature macro: ALU_ARB_RR_EN. When it is defined, a round-robin
// pointer picks the winner when both requesters ask at once. When it is
// undefined, requester 0 always wins.
module alu_arbiter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  input  logic [2:0]  Op0,
  input  logic [2:0]  Op1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [2:0]  AluOp,
  input  logic [31:0] AluR,
  input  logic        AluC,
  input  logic        AluV,
  input  logic        AluZ,
  output logic        RspValid,
  input  logic        RspAck,
  output logic        RspId,
  output logic [31:0] RspR,
  output logic        RspC,
  output logic        RspV,
  output logic        RspZ,
  output logic        Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_xfer;
  logic        w_prefer1;

  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_op;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_r;
  logic        r_rsp_c;
  logic        r_rsp_v;
  logic        r_rsp_z;

`ifdef ALU_ARB_RR_EN
  // r_ptr = 1 means requester 1 is preferred on the next simultaneous request.
  logic r_ptr;

  // Round-robin pointer: after each grant, point at the requester that was not granted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ptr <= 1'b0;
    end else if (w_xfer) begin
      r_ptr <= w_gnt0;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_prefer1 = r_ptr;
`else
  assign w_prefer1 = 1'b0;
`endif

  assign w_xfer = w_gnt0 | w_gnt1;

  // Grant decode: combinational from the requests and the state only, and forced low during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!Rst && (r_state == ST_IDLE)) begin
      if (Req0 && Req1) begin
        w_gnt0 = ~w_prefer1;
        w_gnt1 = w_prefer1;
      end else begin
        w_gnt0 = Req0;
        w_gnt1 = Req1;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP operation sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (RspAck) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand/op issue registers: load on a transfer and hold the last issued values otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_alu_a  <= 32'd0;
      r_alu_b  <= 32'd0;
      r_alu_op <= 3'd0;
      r_rsp_id <= 1'b0;
    end else if (w_xfer) begin
      r_alu_a  <= w_gnt1 ? A1  : A0;
      r_alu_b  <= w_gnt1 ? B1  : B0;
      r_alu_op <= w_gnt1 ? Op1 : Op0;
      r_rsp_id <= w_gnt1;
    end else begin
      r_alu_a  <= r_alu_a;
      r_alu_b  <= r_alu_b;
      r_alu_op <= r_alu_op;
      r_rsp_id <= r_rsp_id;
    end
  end

  // Response capture: sample the ALU at the end of EXEC, and drop valid when the response is acknowledged.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= 32'd0;
      r_rsp_c     <= 1'b0;
      r_rsp_v     <= 1'b0;
      r_rsp_z     <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_r     <= AluR;
      r_rsp_c     <= AluC;
      r_rsp_v     <= AluV;
      r_rsp_z     <= AluZ;
    end else if ((r_state == ST_RESP) && RspAck) begin
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= r_rsp_r;
      r_rsp_c     <= r_rsp_c;
      r_rsp_v     <= r_rsp_v;
      r_rsp_z     <= r_rsp_z;
    end else begin
      r_rsp_valid <= r_rsp_valid;
      r_rsp_r     <= r_rsp_r;
      r_rsp_c     <= r_rsp_c;
      r_rsp_v     <= r_rsp_v;
      r_rsp_z     <= r_rsp_z;
    end
  end

  assign Gnt0     = w_gnt0;
  assign Gnt1     = w_gnt1;
  assign AluA     = r_alu_a;
  assign AluB     = r_alu_b;
  assign AluOp    = r_alu_op;
  assign RspValid = r_rsp_valid;
  assign RspId    = r_rsp_id;
  assign RspR     = r_rsp_r;
  assign RspC     = r_rsp_c;
  assign RspV     = r_rsp_v;
  assign RspZ     = r_rsp_z;
  assign Busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. It contains a behavioural ALU and an
// arithmetic reference model, and it follows ALU_ARB_RR_EN for the expected
// arbitration policy.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0, Req1;
  logic [31:0] A0, B0, A1, B1;
  logic [2:0]  Op0, Op1;
  logic        Gnt0, Gnt1;
  logic [31:0] AluA, AluB;
  logic [2:0]  AluOp;
  logic [31:0] AluR;
  logic        AluC, AluV, AluZ;
  logic        RspValid, RspAck, RspId;
  logic [31:0] RspR;
  logic        RspC, RspV, RspZ;
  logic        Busy;

  int n_total = 0;
  int n_pass  = 0;
  int pref    = 0;
  int won;
  int seq[4];
  logic [2:0] op_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  alu_arbiter dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .Op0(Op0), .Op1(Op1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
    .AluR(AluR), .AluC(AluC), .AluV(AluV), .AluZ(AluZ),
    .RspValid(RspValid), .RspAck(RspAck), .RspId(RspId), .RspR(RspR),
    .RspC(RspC), .RspV(RspV), .RspZ(RspZ), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Behavioural ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
  always_comb begin
    logic [32:0] t;
    t    = 33'd0;
    AluC = 1'b0;
    AluV = 1'b0;
    case (AluOp)
      3'b000: t = {1'b0, AluA & AluB};
      3'b001: t = {1'b0, AluA | AluB};
      3'b010: begin
        t    = {1'b0, AluA} + {1'b0, AluB};
        AluC = t[32];
        AluV = (AluA[31] == AluB[31]) && (t[31] != AluA[31]);
      end
      3'b110: begin
        t    = {1'b0, AluA} + {1'b0, ~AluB} + 33'd1;
        AluC = t[32];
        AluV = (AluA[31] != AluB[31]) && (t[31] != AluA[31]);
      end
      3'b111: t = {32'd0, ($signed(AluA) < $signed(AluB))};
      default: t = 33'd0;
    endcase
    AluR = t[31:0];
    AluZ = (t[31:0] == 32'd0);
  end

  // Reference model using plain integer arithmetic. Returns {c, v, z, r}.
  function automatic logic [34:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [31:0] r = 32'd0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r = a + b;
        c = (ua + ub) > 64'sd4294967295;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        r = a - b;
        c = (ua >= ub);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {c, v, (r == 32'd0), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Runs one full operation. The task is entered with the clock low and
  // returns at a falling edge. The losing requester keeps its request raised.
  task automatic txn(input logic r0, input logic r1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] o0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] o1,
                     input int ack_wait, output int w);
    logic [34:0] e;
    int cyc;
    Req0 = r0; Req1 = r1;
    A0 = a0; B0 = b0; Op0 = o0; A1 = a1; B1 = b1; Op1 = o1;
    if (r0 && r1) w = (RR_EN && pref == 1) ? 1 : 0;
    else w = r1 ? 1 : 0;
    #1;
    cyc = 0;
    while (!(Gnt0 || Gnt1) && cyc < 8) begin
      @(negedge Clk); #1; cyc++;
    end
    chk("gnt0", Gnt0, (w == 0));
    chk("gnt1", Gnt1, (w == 1));
    if (!(Gnt0 || Gnt1)) begin
      Req0 = 1'b0; Req1 = 1'b0;
      return;
    end
    e = (w == 1) ? alu_ref(o1, a1, b1) : alu_ref(o0, a0, b0);
    @(posedge Clk); #1;
    if (w == 0) Req0 = 1'b0; else Req1 = 1'b0;
    pref = (w == 0) ? 1 : 0;
    @(negedge Clk);
    chk("exec_busy", Busy, 1'b1);
    chk("exec_valid", RspValid, 1'b0);
    chk("exec_gnt", {Gnt0, Gnt1}, 2'b00);
    chk("exec_alua", AluA, (w == 1) ? a1 : a0);
    chk("exec_aluop", AluOp, (w == 1) ? o1 : o0);
    @(posedge Clk); @(negedge Clk);
    chk("rsp_valid", RspValid, 1'b1);
    chk("rsp_id", RspId, w[0]);
    chk("rsp_r", RspR, e[31:0]);
    chk("rsp_flags", {RspC, RspV, RspZ}, e[34:32]);
    for (int k = 0; k < ack_wait; k++) begin
      @(posedge Clk); @(negedge Clk);
      chk("hold_valid", RspValid, 1'b1);
      chk("hold_r", RspR, e[31:0]);
      chk("hold_gnt", {Gnt0, Gnt1}, 2'b00);
    end
    RspAck = 1'b1;
    @(posedge Clk); #1;
    RspAck = 1'b0;
    @(negedge Clk);
    chk("ack_busy", Busy, 1'b0);
    chk("ack_valid", RspValid, 1'b0);
    chk("gnt_after_ack", Gnt0 | Gnt1, Req0 | Req1);
  endtask

  initial begin
    Rst = 1'b1; Req0 = 1'b1; Req1 = 1'b0; RspAck = 1'b0;
    A0 = 32'd0; B0 = 32'd0; A1 = 32'd0; B1 = 32'd0; Op0 = 3'd0; Op1 = 3'd0;
    @(negedge Clk); @(negedge Clk);
    // Reset state. Req0 is held high to show that grants are suppressed during reset.
    chk("rst_gnt", {Gnt0, Gnt1}, 2'b00);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_valid", RspValid, 1'b0);
    chk("rst_alu", {AluA, AluB}, 64'd0);
    chk("rst_rsp", {RspId, RspC, RspV, RspZ, RspR}, 64'd0);
    Req0 = 1'b0; Rst = 1'b0;
    @(negedge Clk);

    // RspAck while idle is ignored.
    RspAck = 1'b1;
    @(negedge Clk); @(negedge Clk);
    chk("idle_ack_busy", Busy, 1'b0);
    chk("idle_ack_valid", RspValid, 1'b0);
    RspAck = 1'b0;

    // Directed cases.
    txn(1'b1, 1'b0, 32'd5, 32'd7, 3'b010, 32'd0, 32'd0, 3'b000, 0, won);
    chk("t1_r", RspR, 32'd12);
    chk("t1_cz", {RspC, RspZ, RspId}, 3'b000);
    txn(1'b0, 1'b1, 32'd0, 32'd0, 3'b000, 32'h7FFF_FFFF, 32'd1, 3'b010, 5, won);
    chk("t2_r", RspR, 32'h8000_0000);
    chk("t2_vid", {RspV, RspId}, 2'b11);
    txn(1'b0, 1'b1, 32'd0, 32'd0, 3'b000, 32'd9, 32'd9, 3'b110, 1, won);
    chk("t3_r", RspR, 32'd0);
    chk("t3_zc", {RspZ, RspC}, 2'b11);

    // Both requesters held high for four operations.
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 32'd100 + i, 32'd1, 3'b010, 32'd200 + i, 32'd2, 3'b110, 0, won);
      seq[i] = won;
    end
    chk("fair_seq", {seq[0][0], seq[1][0], seq[2][0], seq[3][0]}, RR_EN ? 4'b0101 : 4'b0000);
    Req0 = 1'b0; Req1 = 1'b0;

    // Reset asserted during EXEC discards the operation.
    A0 = 32'd3; B0 = 32'd4; Op0 = 3'b010; Req0 = 1'b1;
    #1;
    chk("rx_gnt", Gnt0, 1'b1);
    @(posedge Clk); #1;
    Rst = 1'b1;
    #1;
    chk("rx_busy", Busy, 1'b0);
    chk("rx_valid", RspValid, 1'b0);
    chk("rx_gnt_held", {Gnt0, Gnt1}, 2'b00);
    chk("rx_out", {AluA, AluB}, 64'd0);
    chk("rx_rsp", {AluOp, RspId, RspC, RspV, RspZ, RspR}, 64'd0);
    @(posedge Clk); @(negedge Clk);
    Req0 = 1'b0; Rst = 1'b0; pref = 0;
    @(negedge Clk);
    chk("rx_after_valid", RspValid, 1'b0);
    chk("rx_after_busy", Busy, 1'b0);
    txn(1'b0, 1'b1, 32'd0, 32'd0, 3'b000, 32'd20, 32'd22, 3'b010, 0, won);
    chk("rx_new_id", RspId, 1'b1);
    chk("rx_new_r", RspR, 32'd42);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      txn(pat[0], pat[1], $urandom, $urandom, op_tab[$urandom_range(0, 4)],
          $urandom, $urandom, op_tab[$urandom_range(0, 4)], int'($urandom_range(0, 3)), won);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
